// File: rtl/fg_sched_pkg.sv
// Shared constants for the foreground line scheduler: FSM encoding, OBM field
// offsets, attribute bit positions and pattern geometry.
package fg_sched_pkg;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_YP    = 4'd1;
    localparam logic [3:0] ST_CHK   = 4'd2;
    localparam logic [3:0] ST_XP    = 4'd3;
    localparam logic [3:0] ST_ATTR  = 4'd4;
    localparam logic [3:0] ST_COLOR = 4'd5;
    localparam logic [3:0] ST_PAT0  = 4'd6;
    localparam logic [3:0] ST_PAT1  = 4'd7;
    localparam logic [3:0] ST_WRITE = 4'd8;
    localparam logic [3:0] ST_DONE  = 4'd9;

    typedef logic [3:0] fg_state_t;

    localparam logic [1:0] OBM_XP    = 2'd0;
    localparam logic [1:0] OBM_YP    = 2'd1;
    localparam logic [1:0] OBM_ATTR  = 2'd2;
    localparam logic [1:0] OBM_COLOR = 2'd3;

    localparam int ATTR_HFLIP    = 6;
    localparam int ATTR_VFLIP    = 5;
    localparam int ATTR_PMFA_MSB = 4;

    localparam int PATTERN_ROW_W = 16;
    localparam int OBJ_HEIGHT    = 8;

endpackage

// File: rtl/fg_line_scheduler_if.sv
// Memory read ports and sprite-slot write port of the foreground line scheduler.
interface fg_line_scheduler_if #(
    parameter int SLOT_W = 3
);
    // obm_re/pmf_re qualify their address for one cycle; the matching data is
    // returned on the following cycle. slot_we is a single-cycle write with no
    // back-pressure: the slot table must accept it in that cycle.
    logic              obm_re;
    logic [7:0]        obm_addr;
    logic [7:0]        obm_data;
    logic              pmf_re;
    logic [8:0]        pmf_addr;
    logic [7:0]        pmf_data;
    logic              slot_we;
    logic [SLOT_W-1:0] slot_idx;
    logic [7:0]        slot_xp;
    logic [2:0]        slot_color;
    logic              slot_hflip;
    logic [15:0]       slot_pattern;

    modport master (
        output obm_re, obm_addr, input obm_data,
        output pmf_re, pmf_addr, input pmf_data,
        output slot_we, slot_idx, slot_xp, slot_color, slot_hflip, slot_pattern
    );

    modport slave (
        input  obm_re, obm_addr, output obm_data,
        input  pmf_re, pmf_addr, output pmf_data,
        input  slot_we, slot_idx, slot_xp, slot_color, slot_hflip, slot_pattern
    );
endinterface

// File: rtl/fg_pattern_hflip.sv
// Mirrors a 16-bit pattern row by reversing its eight 2-bit pixels.
// Only compiled when FG_HFLIP_EN is defined.
`ifdef FG_HFLIP_EN
module fg_pattern_hflip
    import fg_sched_pkg::*;
(
    input  logic [PATTERN_ROW_W-1:0] i_pattern,
    output logic [PATTERN_ROW_W-1:0] o_pattern
);
    for (genvar g = 0; g < PATTERN_ROW_W / 2; g++) begin : g_pix
        assign o_pattern[2*g +: 2] = i_pattern[PATTERN_ROW_W-2-2*g +: 2];
    end
endmodule
`endif

// File: rtl/fg_line_scheduler.sv
// Per-scanline foreground object evaluator: scans OBM, fetches pattern rows of
// hits from PMF and fills the sprite-slot table. FG_HFLIP_EN flips rows here.
module fg_line_scheduler
    import fg_sched_pkg::*;
#(
    parameter int NUM_OBJECTS      = 64,
    parameter int MAX_OBJ_PER_LINE = 8,
    parameter int SLOT_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        next_y,
    output logic              busy,
    output logic              done,
    output logic [SLOT_W:0]   slot_count,
    output logic              overflow,
    output logic [3:0]        o_dbg_state,
    fg_line_scheduler_if.master bus
);
    localparam logic [SLOT_W:0] MAX_CNT  = (SLOT_W+1)'(MAX_OBJ_PER_LINE);
    localparam logic [5:0]      LAST_OBJ = 6'(NUM_OBJECTS - 1);

    fg_state_t       r_state;
    logic [7:0]      r_y;
    logic [5:0]      r_obj;
    logic [2:0]      r_row;
    logic [7:0]      r_xp;
    logic            r_hflip;
    logic [4:0]      r_pmfa;
    logic [2:0]      r_color;
    logic [7:0]      r_pat0;
    logic [7:0]      r_pat1;
    logic [SLOT_W:0] r_count;
    logic            r_ovf;

    logic [7:0]  w_d;
    logic        w_hit;
    logic        w_full;
    logic        w_last;
    logic [15:0] w_pattern;
    logic        w_hflip_out;

    // Unsigned wrap of next_y - yp makes yp near 255 cover the top lines.
    assign w_d    = r_y - bus.obm_data;
    assign w_hit  = (w_d < 8'(OBJ_HEIGHT));
    assign w_full = (r_count == MAX_CNT);
    assign w_last = (r_obj == LAST_OBJ);

`ifdef FG_HFLIP_EN
    logic [15:0] w_flipped;

    fg_pattern_hflip u_hflip (
        .i_pattern (({r_pat0, r_pat1})),
        .o_pattern (w_flipped)
    );

    assign w_pattern   = r_hflip ? w_flipped : {r_pat0, r_pat1};
    assign w_hflip_out = 1'b0;
`else
    assign w_pattern   = {r_pat0, r_pat1};
    assign w_hflip_out = r_hflip;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_obj   <= '0;
            r_row   <= '0;
            r_xp    <= '0;
            r_hflip <= 1'b0;
            r_pmfa  <= '0;
            r_color <= '0;
            r_pat0  <= '0;
            r_pat1  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_y     <= next_y;
                    r_obj   <= '0;
                    r_state <= ST_YP;
                end
                ST_YP: r_state <= ST_CHK;
                ST_CHK: begin
                    if (!w_hit) begin
                        r_obj   <= w_last ? r_obj : r_obj + 6'd1;
                        r_state <= w_last ? ST_DONE : ST_YP;
                    end else if (w_full) begin
                        r_ovf   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_row   <= w_d[2:0];
                        r_state <= ST_XP;
                    end
                end
                ST_XP: begin
                    r_xp    <= bus.obm_data;
                    r_state <= ST_ATTR;
                end
                ST_ATTR: begin
                    r_hflip <= bus.obm_data[ATTR_HFLIP];
                    r_pmfa  <= bus.obm_data[ATTR_PMFA_MSB:0];
                    r_row   <= r_row ^ {3{bus.obm_data[ATTR_VFLIP]}};
                    r_state <= ST_COLOR;
                end
                ST_COLOR: begin
                    r_color <= bus.obm_data[2:0];
                    r_state <= ST_PAT0;
                end
                ST_PAT0: begin
                    r_pat0  <= bus.pmf_data;
                    r_state <= ST_PAT1;
                end
                ST_PAT1: begin
                    r_pat1  <= bus.pmf_data;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_count <= r_count + (SLOT_W+1)'(1);
                    r_obj   <= w_last ? r_obj : r_obj + 6'd1;
                    r_state <= w_last ? ST_DONE : ST_YP;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.obm_re       = 1'b0;
        bus.obm_addr     = '0;
        bus.pmf_re       = 1'b0;
        bus.pmf_addr     = '0;
        bus.slot_we      = 1'b0;
        bus.slot_idx     = '0;
        bus.slot_xp      = '0;
        bus.slot_color   = '0;
        bus.slot_hflip   = 1'b0;
        bus.slot_pattern = '0;
        case (r_state)
            ST_YP: begin
                bus.obm_re   = 1'b1;
                bus.obm_addr = {r_obj, OBM_YP};
            end
            ST_CHK: if (w_hit && !w_full) begin
                bus.obm_re   = 1'b1;
                bus.obm_addr = {r_obj, OBM_XP};
            end
            ST_XP: begin
                bus.obm_re   = 1'b1;
                bus.obm_addr = {r_obj, OBM_ATTR};
            end
            ST_ATTR: begin
                bus.obm_re   = 1'b1;
                bus.obm_addr = {r_obj, OBM_COLOR};
            end
            ST_COLOR: begin
                bus.pmf_re   = 1'b1;
                bus.pmf_addr = {r_pmfa, r_row, 1'b0};
            end
            ST_PAT0: begin
                bus.pmf_re   = 1'b1;
                bus.pmf_addr = {r_pmfa, r_row, 1'b1};
            end
            ST_WRITE: begin
                bus.slot_we      = 1'b1;
                bus.slot_idx     = r_count[SLOT_W-1:0];
                bus.slot_xp      = r_xp;
                bus.slot_color   = r_color;
                bus.slot_hflip   = w_hflip_out;
                bus.slot_pattern = w_pattern;
            end
            default: ;
        endcase
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign slot_count  = r_count;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fg_line_scheduler.sv
// Randomized and directed bench for fg_line_scheduler against a scan-level
// reference model of the OBM/PMF contents.
module tb_fg_line_scheduler;
    localparam int NUM = 64;
    localparam int MAX = 8;
    localparam int SW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    next_y = '0;
    logic          busy;
    logic          done;
    logic [SW:0]   slot_count;
    logic          overflow;
    logic [3:0]    dbg_state;

    fg_line_scheduler_if #(.SLOT_W(SW)) bus ();

    fg_line_scheduler #(
        .NUM_OBJECTS      (NUM),
        .MAX_OBJ_PER_LINE (MAX),
        .SLOT_W           (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .next_y      (next_y),
        .busy        (busy),
        .done        (done),
        .slot_count  (slot_count),
        .overflow    (overflow),
        .o_dbg_state (dbg_state),
        .bus         (bus)
    );

    // clock / reset
    always #40 clk = ~clk;

    logic [7:0] obm_mem [256];
    logic [7:0] pmf_mem [512];

    // synchronous memories; garbage when not strobed
    always @(posedge clk) begin
        bus.obm_data <= bus.obm_re ? obm_mem[bus.obm_addr] : 8'($urandom);
        bus.pmf_data <= bus.pmf_re ? pmf_mem[bus.pmf_addr] : 8'($urandom);
    end

    int n_total = 0;
    int n_bad   = 0;
    int n_writes = 0;
    int n_extra  = 0;
    int viol     = 0;
    logic [30:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: slot writes and idle-address monitor
    always @(negedge clk) begin
        if (rst) begin
            if (!bus.obm_re && bus.obm_addr != 8'd0) viol++;
            if (!bus.pmf_re && bus.pmf_addr != 9'd0) viol++;
            if (bus.slot_we) begin
                n_writes++;
                if (exp_q.size() == 0) n_extra++;
                else check("slot_rec",
                           {bus.slot_idx, bus.slot_xp, bus.slot_color, bus.slot_hflip, bus.slot_pattern},
                           exp_q.pop_front());
            end
        end
    end

    function automatic logic [63:0] outs();
        return {2'b0, busy, done, bus.obm_re, bus.obm_addr, bus.pmf_re, bus.pmf_addr,
                bus.slot_we, bus.slot_idx, bus.slot_xp, bus.slot_color, bus.slot_hflip,
                bus.slot_pattern, slot_count, overflow, dbg_state};
    endfunction

    function automatic logic [15:0] flip_row(input logic [15:0] p);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = p[14-2*i +: 2];
        return r;
    endfunction

    // reference model: walks objects in order, pushes expected slot records
    task automatic model_scan(input logic [7:0] y, output int lat, output int cnt, output bit ovf);
        logic [7:0]  d;
        logic [7:0]  attr;
        logic [2:0]  row;
        logic [15:0] pat;
        logic        hf;
        int          pa;
        lat = 0; cnt = 0; ovf = 1'b0;
        for (int o = 0; o < NUM; o++) begin
            d = y - obm_mem[o*4+1];
            if (d >= 8) begin
                lat += 2;
                continue;
            end
            if (cnt == MAX) begin
                ovf = 1'b1;
                lat += 2;
                break;
            end
            attr = obm_mem[o*4+2];
            row  = attr[5] ? 3'd7 - d[2:0] : d[2:0];
            pa   = attr[4:0] * 16 + row * 2;
            pat  = {pmf_mem[pa], pmf_mem[pa+1]};
            hf   = attr[6];
`ifdef FG_HFLIP_EN
            if (hf) pat = flip_row(pat);
            hf = 1'b0;
`endif
            exp_q.push_back({3'(cnt), obm_mem[o*4], obm_mem[o*4+3][2:0], hf, pat});
            cnt++;
            lat += 8;
        end
        lat += 1;
    endtask

    task automatic fill_miss();
        for (int i = 0; i < 256; i++) obm_mem[i] = 8'($urandom);
        for (int o = 0; o < NUM; o++) obm_mem[o*4+1] = 8'd200;
        for (int i = 0; i < 512; i++) pmf_mem[i] = 8'($urandom);
    endtask

    // driver: one scan, optional extra start pulse at cycle 'glitch' while busy
    task automatic run_scan(input logic [7:0] y, input int glitch, input string name);
        int lat, cnt, cyc, done_at;
        bit ovf;
        model_scan(y, lat, cnt, ovf);
        viol = 0;
        n_extra = 0;
        @(negedge clk);
        start = 1'b1;
        next_y = y;
        done_at = -1;
        cyc = 0;
        while (cyc < 2000 && done_at < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == glitch);
            next_y = 8'($urandom);
            if (done) begin
                done_at = cyc;
                check({name, "_busy_at_done"}, busy, 1);
            end
        end
        start = 1'b0;
        check({name, "_done_lat"}, done_at, lat);
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_slot_count"}, slot_count, cnt);
        check({name, "_overflow"}, overflow, ovf);
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_extra_wr"}, n_extra, 0);
        check({name, "_idle_addr"}, viol, 0);
        exp_q.delete();
    endtask

    initial begin
        int target;
        int cyc;
        logic [7:0] y;

        fill_miss();
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), 0);

        // all objects off the line
        run_scan(8'd10, 0, "t1");

        // single hit, row 2
        fill_miss();
        obm_mem[20] = 8'd40; obm_mem[21] = 8'd10; obm_mem[22] = 8'h03; obm_mem[23] = 8'd2;
        pmf_mem[52] = 8'hA5; pmf_mem[53] = 8'h3C;
        pmf_mem[58] = 8'h5E; pmf_mem[59] = 8'h71;
        run_scan(8'd12, 0, "t2");

        // vflip: row 2 becomes row 5
        obm_mem[22] = 8'h23;
        run_scan(8'd12, 0, "t3a");

        // hflip
        obm_mem[22] = 8'h43;
        run_scan(8'd12, 0, "t4");

        // wrap: yp=252 covers line 2 at row 6
        fill_miss();
        obm_mem[36] = 8'd77; obm_mem[37] = 8'd252; obm_mem[38] = 8'h01; obm_mem[39] = 8'd5;
        run_scan(8'd2, 0, "t3b");

        // nine hits on line 50, extra start while busy
        fill_miss();
        for (int k = 0; k < 9; k++) obm_mem[(3 + 7*k)*4 + 1] = 8'(50 - $urandom_range(0, 7));
        run_scan(8'd50, 5, "t5");

        // reset mid-scan after three writes
        fill_miss();
        for (int k = 0; k < 6; k++) obm_mem[(2 + 10*k)*4 + 1] = 8'(100 - $urandom_range(0, 7));
        begin
            int lat, cnt;
            bit ovf;
            model_scan(8'd100, lat, cnt, ovf);
        end
        target = n_writes + 3;
        @(negedge clk);
        start = 1'b1;
        next_y = 8'd100;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 500 && n_writes < target) begin
            @(posedge clk);
            cyc++;
        end
        check("t6_reached_3", n_writes, target);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_reset_outs", outs(), 0);
        rst = 1'b1;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("t6_no_more_wr", n_writes, target);
        check("t6_still_idle", outs(), 0);
        run_scan(8'd100, 4, "t6b");

        // randomized scans
        for (int t = 0; t < 20; t++) begin
            y = 8'($urandom);
            for (int i = 0; i < 256; i++) obm_mem[i] = 8'($urandom);
            for (int i = 0; i < 512; i++) pmf_mem[i] = 8'($urandom);
            for (int o = 0; o < NUM; o++)
                if ($urandom_range(0, 3) == 0) obm_mem[o*4+1] = 8'(y - $urandom_range(0, 9));
            run_scan(y, $urandom_range(0, 20), "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fg_line_scheduler.md
Name: fg_line_scheduler

Overview:
- Per-scanline object evaluator for the foreground layer.
- On a start pulse, scans all Object Memory entries to find the objects that cover the requested line, up to MAX_OBJ_PER_LINE of them.
- For each hit, fetches the 16-bit pattern row from Pattern Memory Foreground and writes one record into a downstream sprite-slot table.
- Sits between the video timing generator (line start) and the foreground VRAM read ports and pixel line buffer.

Parameters:
- NUM_OBJECTS, 64, number of OBM entries scanned (4 bytes each).
- MAX_OBJ_PER_LINE, 8, slot-table capacity per line.
- SLOT_W, 3, slot index width, equal to clog2(MAX_OBJ_PER_LINE).

Ports:
- clk  in  1  pixel clock, 12.5875 MHz.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse: begin scan for next_y.
- next_y  in  8  line to evaluate; sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the scan completes.
- obm_re  out  1  OBM read strobe.
- obm_addr  out  8  OBM byte address: {obj[5:0], field[1:0]}.
- obm_data  in  8  OBM read data, valid the cycle after the address is presented.
- pmf_re  out  1  PMF read strobe.
- pmf_addr  out  9  PMF byte address: {pmfa[4:0], row[2:0], half}.
- pmf_data  in  8  PMF read data, 1-cycle latency.
- slot_we  out  1  slot write strobe.
- slot_idx  out  SLOT_W  slot being written.
- slot_xp  out  8  object x.
- slot_color  out  3  object palette.
- slot_hflip  out  1  object hflip bit.
- slot_pattern  out  16  {byte0, byte1} of the pattern row.
- slot_count  out  SLOT_W+1  slots written this scan; held until the next start.
- overflow  out  1  more than MAX_OBJ_PER_LINE hits on the line; held until the next start.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including slot_count and overflow.
  - Applies mid-scan: the scan is aborted, no further slot_we.
- start:
  - Accepted only in IDLE; ignored while busy.
  - An accepted start clears slot_count and overflow, latches next_y, sets obj=0, and moves to S_YP.
- OBM field offsets: 0 = xp, 1 = yp, 2 = attr {–, hflip[6], vflip[5], pmfa[4:0]}, 3 = color[2:0].
- States (each one cycle):
  - S_YP: present {obj,1}; go to S_CHK.
  - S_CHK: d = next_y − obm_data (8-bit, wraps). Hit when d < 8; latch row = d[2:0].
    - Miss: if obj == NUM_OBJECTS−1 go to DONE, else obj++ and go to S_YP.
    - Hit with slot_count == MAX: set overflow, go to DONE.
    - Hit otherwise: present {obj,0}, go to S_XP.
  - S_XP: latch xp; present {obj,2}.
  - S_ATTR: latch hflip, vflip, pmfa; row ^= {3{vflip}}; present {obj,3}.
  - S_COLOR: latch color; present pmf_addr = {pmfa,row,0}.
  - S_PAT0: latch byte0; present {pmfa,row,1}.
  - S_PAT1: latch byte1.
  - S_WRITE: slot_we=1 with slot_idx = slot_count; slot_count++. Then same next-object rule as a miss.
  - DONE: done=1; go to IDLE.
- Cycle cost: a miss costs 2 cycles; a hit costs 8 cycles.
- obm_re / pmf_re are high exactly in the cycles that present an address. Addresses are 0 otherwise.
- Wrap: yp in 249..255 covers lines 0..(yp+7) mod 256.
- slot_count saturates at MAX_OBJ_PER_LINE and is never exceeded.

Optional Feature:
- Macro FG_HFLIP_EN.
- Defined: slot_pattern is horizontally flipped when hflip=1, i.e. the eight 2-bit pixels are reversed in order. Flip is applied combinationally at S_WRITE. slot_hflip is output as 0.
- Undefined: slot_pattern is raw, and slot_hflip carries the hflip bit for the downstream stage to apply.

Decomposition:
- Package fg_sched_pkg holds:
  - the state enum;
  - OBM field offsets (OBM_XP=0, OBM_YP=1, OBM_ATTR=2, OBM_COLOR=3);
  - attr bit positions;
  - PATTERN_ROW_W=16 and OBJ_HEIGHT=8.
- One sub-module, fg_pattern_hflip: combinational 16-bit reversal of the 2-bit pixel groups, instantiated under FG_HFLIP_EN.

Test Plan:
1. All yp=200, start with next_y=10 → no slot_we; done exactly 129 cycles after the start cycle; slot_count=0; overflow=0.
2. Obj 5: yp=10, xp=40, attr=0x03, color=2; PMF[{3,2,0}]=0xA5, PMF[{3,2,1}]=0x3C; next_y=12 → exactly one slot_we with idx 0, xp 40, color 2, pattern 0xA53C; slot_count=1.
3. Same as 2 with vflip (attr=0x23) → pmf_addr uses row 5, i.e. {3,5,0} and {3,5,1}. Obj yp=252 with next_y=2 → hit at row 6.
4. FG_HFLIP_EN defined, attr=0x43, data as in 2 → slot_pattern=0x3C5A, slot_hflip=0. Undefined → pattern 0xA53C, slot_hflip=1.
5. Nine objects on line 50 with MAX=8 → 8 slot_we with idx 0..7; overflow=1; done on the cycle after the 9th hit's S_CHK.
6. rst low mid-scan (after 3 hits) → next cycle all outputs 0, state IDLE. A start pulse while busy has no effect on next_y or the hit results.
